// File: rtl/i2s_loopback_ctrl.sv
// Frame scheduler between the I2S RX and TX cores: assembles L/R pairs into a
// one-frame pending buffer and routes them per mode at each TX frame start.
module i2s_loopback_ctrl #(
  parameter int DATA_W         = 24,
  parameter int STARTUP_FRAMES = 4096,
  parameter int CNT_W          = 8
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              rx_left_valid,
  input  logic [DATA_W-1:0] rx_left_data,
  input  logic              rx_right_valid,
  input  logic [DATA_W-1:0] rx_right_data,
  input  logic              tx_frame_start,
  input  logic [1:0]        mode,
  input  logic              clr_stats,
  output logic [DATA_W-1:0] tx_left_data,
  output logic [DATA_W-1:0] tx_right_data,
  output logic              muted,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic [CNT_W-1:0]  overrun_cnt
);

  localparam int FC_W = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(STARTUP_FRAMES - 1);

  localparam logic TOP_STARTUP = 1'b0;
  localparam logic TOP_RUN     = 1'b1;
  localparam logic ASM_WAIT_L  = 1'b0;
  localparam logic ASM_WAIT_R  = 1'b1;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_SWAP = 2'b01;
  localparam logic [1:0] MODE_MONO = 2'b10;
  localparam logic [1:0] MODE_MUTE = 2'b11;

  logic              top_q, top_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic              asm_q, asm_d;
  logic [DATA_W-1:0] held_l_q, held_l_d;
  logic [DATA_W-1:0] pend_l_q, pend_l_d;
  logic [DATA_W-1:0] pend_r_q, pend_r_d;
  logic              pend_v_q, pend_v_d;
  logic [DATA_W-1:0] tx_l_q, tx_l_d;
  logic [DATA_W-1:0] tx_r_q, tx_r_d;
  logic              muted_q, muted_d;
  logic [CNT_W-1:0]  und_q, und_d;
  logic [CNT_W-1:0]  ovr_q, ovr_d;

  logic              frame_done;
  logic              src_valid;
  logic [DATA_W-1:0] src_l, src_r;
  logic              und_inc, ovr_inc;

  always_comb begin
    top_d      = top_q;
    fc_d       = fc_q;
    asm_d      = asm_q;
    held_l_d   = held_l_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    pend_v_d   = pend_v_q;
    tx_l_d     = tx_l_q;
    tx_r_d     = tx_r_q;
    muted_d    = muted_q;
    frame_done = 1'b0;
    und_inc    = 1'b0;
    ovr_inc    = 1'b0;

    // A simultaneous right pulse is dropped in favour of the left one.
    if (rx_left_valid) begin
      held_l_d = rx_left_data;
      asm_d    = ASM_WAIT_R;
    end else if (rx_right_valid && asm_q == ASM_WAIT_R) begin
      frame_done = 1'b1;
      asm_d      = ASM_WAIT_L;
    end

    // A frame completing on the frame-start cycle bypasses the pending buffer.
    src_valid = frame_done | pend_v_q;
    src_l     = frame_done ? held_l_q      : pend_l_q;
    src_r     = frame_done ? rx_right_data : pend_r_q;

    if (tx_frame_start) begin
      pend_v_d = 1'b0;
      if (top_q == TOP_STARTUP) begin
        tx_l_d = '0;
        tx_r_d = '0;
        if (fc_q == FC_LAST) begin
          top_d   = TOP_RUN;
          muted_d = (mode == MODE_MUTE);
        end else begin
          fc_d    = fc_q + 1'b1;
          muted_d = 1'b1;
        end
      end else begin
        muted_d = (mode == MODE_MUTE);
        if (src_valid) begin
          case (mode)
            MODE_PASS: begin tx_l_d = src_l; tx_r_d = src_r; end
            MODE_SWAP: begin tx_l_d = src_r; tx_r_d = src_l; end
            MODE_MONO: begin tx_l_d = src_l; tx_r_d = src_l; end
            default:   begin tx_l_d = '0;    tx_r_d = '0;    end
          endcase
        end else begin
          und_inc = 1'b1;
        end
      end
    end else if (frame_done) begin
      ovr_inc  = pend_v_q;
      pend_l_d = held_l_q;
      pend_r_d = rx_right_data;
      pend_v_d = 1'b1;
    end

    if (clr_stats)                  und_d = '0;
    else if (und_inc && und_q != '1) und_d = und_q + 1'b1;
    else                            und_d = und_q;

    if (clr_stats)                  ovr_d = '0;
    else if (ovr_inc && ovr_q != '1) ovr_d = ovr_q + 1'b1;
    else                            ovr_d = ovr_q;
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      top_q    <= (STARTUP_FRAMES == 0) ? TOP_RUN : TOP_STARTUP;
      fc_q     <= '0;
      asm_q    <= ASM_WAIT_L;
      held_l_q <= '0;
      pend_l_q <= '0;
      pend_r_q <= '0;
      pend_v_q <= 1'b0;
      tx_l_q   <= '0;
      tx_r_q   <= '0;
      muted_q  <= (STARTUP_FRAMES != 0);
      und_q    <= '0;
      ovr_q    <= '0;
    end else begin
      top_q    <= top_d;
      fc_q     <= fc_d;
      asm_q    <= asm_d;
      held_l_q <= held_l_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      pend_v_q <= pend_v_d;
      tx_l_q   <= tx_l_d;
      tx_r_q   <= tx_r_d;
      muted_q  <= muted_d;
      und_q    <= und_d;
      ovr_q    <= ovr_d;
    end
  end

  assign tx_left_data  = tx_l_q;
  assign tx_right_data = tx_r_q;
  assign muted         = muted_q;
  assign underrun_cnt  = und_q;
  assign overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_i2s_loopback_ctrl.sv
// Directed bench for i2s_loopback_ctrl with a frame-level reference model.
module tb_i2s_loopback_ctrl;

  localparam int DW = 24;
  localparam int SF = 2;
  localparam int CW = 8;

  logic          clk_25m = 1'b0;
  logic          rst_n   = 1'b1;
  logic          rx_left_valid = 1'b0;
  logic [DW-1:0] rx_left_data  = '0;
  logic          rx_right_valid = 1'b0;
  logic [DW-1:0] rx_right_data  = '0;
  logic          tx_frame_start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          clr_stats = 1'b0;
  logic [DW-1:0] tx_left_data, tx_right_data;
  logic          muted;
  logic [CW-1:0] underrun_cnt, overrun_cnt;

  i2s_loopback_ctrl #(
    .DATA_W(DW),
    .STARTUP_FRAMES(SF),
    .CNT_W(CW)
  ) dut (
    .clk_25m(clk_25m),
    .rst_n(rst_n),
    .rx_left_valid(rx_left_valid),
    .rx_left_data(rx_left_data),
    .rx_right_valid(rx_right_valid),
    .rx_right_data(rx_right_data),
    .tx_frame_start(tx_frame_start),
    .mode(mode),
    .clr_stats(clr_stats),
    .tx_left_data(tx_left_data),
    .tx_right_data(tx_right_data),
    .muted(muted),
    .underrun_cnt(underrun_cnt),
    .overrun_cnt(overrun_cnt)
  );

  always #20 clk_25m = ~clk_25m;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending frames kept as a queue of {L,R} words.
  logic [DW-1:0]   m_l = '0, m_r = '0, m_hold = '0, fl, fr;
  logic [2*DW-1:0] pq[$];
  bit m_muted = 1'b1, m_run = 1'b0, m_have = 1'b0, done, got;
  int m_frames = 0, m_under = 0, m_over = 0;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  always @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      m_l = '0; m_r = '0; m_muted = 1'b1; m_run = 1'b0; m_have = 1'b0;
      m_frames = 0; m_under = 0; m_over = 0; pq.delete();
    end else begin
      done = 1'b0; fl = '0; fr = '0;
      if (rx_left_valid) begin
        m_hold = rx_left_data; m_have = 1'b1;
      end else if (rx_right_valid && m_have) begin
        done = 1'b1; m_have = 1'b0; fl = m_hold; fr = rx_right_data;
      end
      if (tx_frame_start) begin
        got = done || (pq.size() != 0);
        if (!done && pq.size() != 0) {fl, fr} = pq[0];
        pq.delete();
        if (!m_run) begin
          m_l = '0; m_r = '0; m_frames++;
          if (m_frames >= SF) m_run = 1'b1;
          m_muted = m_run ? (mode == 2'b11) : 1'b1;
        end else begin
          m_muted = (mode == 2'b11);
          if (!got) m_under = sat(m_under + 1);
          else if (mode == 2'b00) begin m_l = fl; m_r = fr; end
          else if (mode == 2'b01) begin m_l = fr; m_r = fl; end
          else if (mode == 2'b10) begin m_l = fl; m_r = fl; end
          else begin m_l = '0; m_r = '0; end
        end
      end else if (done) begin
        if (pq.size() != 0) m_over = sat(m_over + 1);
        pq.delete();
        pq.push_back({fl, fr});
      end
      if (clr_stats) begin m_under = 0; m_over = 0; end
    end
  end

  always @(negedge clk_25m) begin
    if (chk_en) begin
      chk("model_tx_left", int'(tx_left_data), int'(m_l));
      chk("model_tx_right", int'(tx_right_data), int'(m_r));
      chk("model_muted", int'(muted), int'(m_muted));
      chk("model_underrun", int'(underrun_cnt), m_under);
      chk("model_overrun", int'(overrun_cnt), m_over);
    end
  end

  task automatic rx_l(input logic [DW-1:0] d);
    rx_left_valid = 1'b1; rx_left_data = d;
    @(negedge clk_25m);
    rx_left_valid = 1'b0;
  endtask

  task automatic rx_r(input logic [DW-1:0] d);
    rx_right_valid = 1'b1; rx_right_data = d;
    @(negedge clk_25m);
    rx_right_valid = 1'b0;
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    rx_l(l);
    rx_r(r);
  endtask

  task automatic pulse_fs();
    tx_frame_start = 1'b1;
    @(negedge clk_25m);
    tx_frame_start = 1'b0;
  endtask

  task automatic lit(input string tag, input int l, input int r, input int m);
    chk({tag, "_left"}, int'(tx_left_data), l);
    chk({tag, "_right"}, int'(tx_right_data), r);
    chk({tag, "_muted"}, int'(muted), m);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #3 chk_en = 1'b1;
    #1 lit("reset", 0, 0, 1);
    chk("reset_underrun", int'(underrun_cnt), 0);
    chk("reset_overrun", int'(overrun_cnt), 0);
    @(negedge clk_25m);
    #5 rst_n = 1'b1;
    @(negedge clk_25m);

    // Startup mute over two frame starts
    frame(24'hABCDEF, 24'h000001); pulse_fs(); lit("startup1", 0, 0, 1);
    frame(24'hABCDEF, 24'h000001); pulse_fs(); lit("startup2", 0, 0, 0);
    frame(24'hABCDEF, 24'h000001); pulse_fs(); lit("run1", 'hABCDEF, 'h000001, 0);
    chk("startup_no_underrun", int'(underrun_cnt), 0);

    // Modes
    mode = 2'b01; frame(24'h123456, 24'h654321); pulse_fs();
    lit("swap", 'h654321, 'h123456, 0);
    mode = 2'b10; frame(24'h123456, 24'h654321); pulse_fs();
    lit("mono", 'h123456, 'h123456, 0);
    mode = 2'b11; frame(24'h123456, 24'h654321); pulse_fs();
    lit("mute", 0, 0, 1);
    mode = 2'b00;

    // Overrun then underrun
    frame(24'h000001, 24'h000002);
    frame(24'h000003, 24'h000004);
    chk("overrun_one", int'(overrun_cnt), 1);
    pulse_fs(); lit("overrun_out", 'h3, 'h4, 0);
    pulse_fs(); lit("underrun_hold", 'h3, 'h4, 0);
    chk("underrun_one", int'(underrun_cnt), 1);

    // Saturation and clear priority
    for (int i = 0; i < 300; i++) pulse_fs();
    chk("underrun_sat", int'(underrun_cnt), 255);
    clr_stats = 1'b1; pulse_fs(); clr_stats = 1'b0;
    chk("clr_underrun", int'(underrun_cnt), 0);
    chk("clr_overrun", int'(overrun_cnt), 0);

    // Stray right, replaced left
    rx_r(24'h000DDD); rx_l(24'h000AAA); rx_l(24'h000BBB); rx_r(24'h000CCC);
    pulse_fs(); lit("stray", 'hBBB, 'hCCC, 0);

    // Both valids together: left wins
    rx_left_valid = 1'b1; rx_left_data = 24'h000777;
    rx_right_valid = 1'b1; rx_right_data = 24'h000888;
    @(negedge clk_25m);
    rx_left_valid = 1'b0; rx_right_valid = 1'b0;
    rx_r(24'h000999);
    pulse_fs(); lit("both_valid", 'h777, 'h999, 0);

    // Bypass with an older frame pending
    frame(24'h000005, 24'h000006);
    rx_l(24'h111111);
    rx_right_valid = 1'b1; rx_right_data = 24'h222222; tx_frame_start = 1'b1;
    @(negedge clk_25m);
    rx_right_valid = 1'b0; tx_frame_start = 1'b0;
    lit("bypass", 'h111111, 'h222222, 0);
    chk("bypass_underrun", int'(underrun_cnt), 0);
    chk("bypass_overrun", int'(overrun_cnt), 0);
    pulse_fs(); lit("bypass_drained", 'h111111, 'h222222, 0);
    chk("bypass_drained_underrun", int'(underrun_cnt), 1);

    // Asynchronous reset mid-frame discards the held left sample
    rx_l(24'h000333);
    #7 rst_n = 1'b0;
    #1 lit("async_reset", 0, 0, 1);
    chk("async_underrun", int'(underrun_cnt), 0);
    chk("async_overrun", int'(overrun_cnt), 0);
    @(negedge clk_25m);
    #5 rst_n = 1'b1;
    @(negedge clk_25m);
    pulse_fs(); pulse_fs();
    rx_r(24'h000444);
    pulse_fs(); lit("partial_discarded", 0, 0, 0);
    chk("partial_underrun", int'(underrun_cnt), 1);
    frame(24'h000555, 24'h000666);
    pulse_fs(); lit("after_reset", 'h555, 'h666, 0);

    @(negedge clk_25m);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
